// File: rtl/reg_debug_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// reg_debug_sequencer_pkg
// Shared definitions for the debug register-access sequencer: the processor
// "halted" state code, the sequencer FSM encodings and the default halt
// timeout. Kept in one place so other debug-unit blocks can reuse them.
// ---------------------------------------------------------------------------
package reg_debug_sequencer_pkg;

   // Processor state code reported by the core when it is halted.
   localparam logic [2:0] STATE_HALTED = 3'd3;

   // Default number of cycles to wait for the core to halt.
   localparam int DEFAULT_HALT_TIMEOUT = 255;

   // Sequencer FSM encodings.
   localparam logic [2:0] ENC_IDLE      = 3'd0;
   localparam logic [2:0] ENC_HALT_WAIT = 3'd1;
   localparam logic [2:0] ENC_RD_ACCESS = 3'd2;
   localparam logic [2:0] ENC_RD_RESP   = 3'd3;
   localparam logic [2:0] ENC_WR_ACCESS = 3'd4;
   localparam logic [2:0] ENC_WR_RESP   = 3'd5;
   localparam logic [2:0] ENC_ERR_RESP  = 3'd6;

   typedef enum logic [2:0] {
      IDLE      = ENC_IDLE,
      HALT_WAIT = ENC_HALT_WAIT,
      RD_ACCESS = ENC_RD_ACCESS,
      RD_RESP   = ENC_RD_RESP,
      WR_ACCESS = ENC_WR_ACCESS,
      WR_RESP   = ENC_WR_RESP,
      ERR_RESP  = ENC_ERR_RESP
   } seq_state_e;

endpackage

// File: rtl/reg_debug_sequencer_timeout_counter.sv
// ---------------------------------------------------------------------------
// dbg_timeout_counter
// Counts enabled cycles from zero and flags when the count reaches LIMIT.
// The count saturates at LIMIT so expired stays high until cleared.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clear   in  force count back to zero
//   enable  in  count this cycle
//   expired out count == LIMIT
// ---------------------------------------------------------------------------
module dbg_timeout_counter
   import reg_debug_sequencer_pkg::*;
#(
   parameter int LIMIT = DEFAULT_HALT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= '0;
      end else if (enable && !expired) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign expired = (count_q == W'(LIMIT));

endmodule

// File: rtl/reg_debug_sequencer.sv
// ---------------------------------------------------------------------------
// reg_debug_sequencer
// Sequences debug-unit single/burst register reads and writes onto the
// register file debug port. Halts the core first (with timeout), then
// performs one register access per step and returns data/status on a
// response channel.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   state                          processor state (halted == STATE_HALTED)
//   halt_req                       halt request to the core
//   req_valid/ready/write/regnum/count   burst request channel
//   wdata_valid/ready, wdata       write word channel
//   rsp_valid/ready/data/last/err  response channel
//   dbg_reg_rregnum, dbg_reg_rdata register file debug read port
//   dbg_reg_wregnum/wdata/we       register file debug write port
//   busy                           sequencer not idle
// ---------------------------------------------------------------------------
module reg_debug_sequencer
   import reg_debug_sequencer_pkg::*;
#(
   parameter int NUM_REGS     = 16,
   parameter int HALT_TIMEOUT = DEFAULT_HALT_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  state,
   output logic        halt_req,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [5:0]  req_regnum,
   input  logic [3:0]  req_count,
   input  logic        wdata_valid,
   output logic        wdata_ready,
   input  logic [15:0] wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_last,
   output logic        rsp_err,
   output logic [5:0]  dbg_reg_rregnum,
   input  logic [15:0] dbg_reg_rdata,
   output logic [5:0]  dbg_reg_wregnum,
   output logic [15:0] dbg_reg_wdata,
   output logic        dbg_reg_we,
   output logic        busy
);

   localparam logic [5:0] LAST_REG = 6'(NUM_REGS - 1);

   seq_state_e  state_q, state_d;
   logic        write_q;
   logic        bad_reg_q;    // current ERR_RESP came from a bad regnum
   logic [5:0]  cur_q;
   logic [3:0]  remaining_q;
   logic [15:0] rdata_q;

   logic        halted;
   logic        bad_regnum;
   logic        req_fire;
   logic        wr_fire;
   logic        timeout_expired;
   logic [5:0]  cur_next;

   assign halted     = (state == STATE_HALTED);
   assign bad_regnum = (req_regnum > LAST_REG);
   assign req_fire   = req_valid && req_ready;
   assign wr_fire    = wdata_valid && wdata_ready;
   assign cur_next   = (cur_q == LAST_REG) ? 6'd0 : cur_q + 6'd1;

   // Counter runs only while waiting for halt; it is held at zero otherwise,
   // so each HALT_WAIT visit starts from a cleared count.
   dbg_timeout_counter #(
      .LIMIT(HALT_TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (state_q != HALT_WAIT),
      .enable (state_q == HALT_WAIT),
      .expired(timeout_expired)
   );

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A halt seen in the expiry cycle wins over the timeout.
   // NOTE: every variable written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (req_fire) state_d = bad_regnum ? ERR_RESP : HALT_WAIT;
         HALT_WAIT: begin
            if (halted)               state_d = write_q ? WR_ACCESS : RD_ACCESS;
            else if (timeout_expired) state_d = ERR_RESP;
         end
         RD_ACCESS: state_d = halted ? RD_RESP : ERR_RESP;
         RD_RESP:   if (rsp_ready) state_d = (remaining_q == 4'd0) ? IDLE : RD_ACCESS;
         WR_ACCESS: begin
            if (!halted)                                 state_d = ERR_RESP;
            else if (wdata_valid && remaining_q == 4'd0) state_d = WR_RESP;
         end
         WR_RESP, ERR_RESP: if (rsp_ready) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Burst bookkeeping and captured read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         write_q     <= 1'b0;
         bad_reg_q   <= 1'b0;
         cur_q       <= '0;
         remaining_q <= '0;
         rdata_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_fire) begin
                  write_q     <= req_write;
                  bad_reg_q   <= bad_regnum;
                  cur_q       <= req_regnum;
                  remaining_q <= req_count;
               end
            end
            RD_ACCESS: if (halted) rdata_q <= dbg_reg_rdata;
            RD_RESP: begin
               if (rsp_ready && remaining_q != 4'd0) begin
                  remaining_q <= remaining_q - 4'd1;
                  cur_q       <= cur_next;
               end
            end
            WR_ACCESS: begin
               if (wr_fire && remaining_q != 4'd0) begin
                  remaining_q <= remaining_q - 4'd1;
                  cur_q       <= cur_next;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs. Handshake outputs toward the debug unit and the write enable
   // are held low while rst is asserted.
   always_comb begin
      req_ready       = 1'b0;
      wdata_ready     = 1'b0;
      dbg_reg_we      = 1'b0;
      dbg_reg_wdata   = '0;
      rsp_valid       = 1'b0;
      rsp_last        = 1'b0;
      rsp_err         = 1'b0;
      rsp_data        = '0;
      busy            = (state_q != IDLE);
      // Halt is never requested for a request rejected on its regnum.
      halt_req        = (state_q != IDLE) && !(state_q == ERR_RESP && bad_reg_q);
      dbg_reg_rregnum = cur_q;
      dbg_reg_wregnum = cur_q;
      unique case (state_q)
         IDLE:      req_ready = !rst;
         WR_ACCESS: begin
            wdata_ready   = halted && !rst;
            dbg_reg_we    = wdata_valid && halted && !rst;
            dbg_reg_wdata = wdata;
         end
         RD_RESP: begin
            rsp_valid = 1'b1;
            rsp_last  = (remaining_q == 4'd0);
            rsp_data  = rdata_q;
         end
         WR_RESP: begin
            rsp_valid = 1'b1;
            rsp_last  = 1'b1;
         end
         ERR_RESP: begin
            rsp_valid = 1'b1;
            rsp_last  = 1'b1;
            rsp_err   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_reg_debug_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_debug_sequencer
// Directed bench: reset, single read, wrapping write burst, bad regnum,
// halt timeout and halt-at-expiry, halt lost mid read, reset mid write,
// and a read burst with response back-pressure. A small register file
// sits on the debug port.
// ---------------------------------------------------------------------------
module tb_reg_debug_sequencer;
   import reg_debug_sequencer_pkg::*;

   localparam logic [2:0] RUNNING = 3'd1;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  state;
   logic        halt_req;
   logic        req_valid, req_ready, req_write;
   logic [5:0]  req_regnum;
   logic [3:0]  req_count;
   logic        wdata_valid, wdata_ready;
   logic [15:0] wdata;
   logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
   logic [15:0] rsp_data;
   logic [5:0]  dbg_reg_rregnum, dbg_reg_wregnum;
   logic [15:0] dbg_reg_rdata, dbg_reg_wdata;
   logic        dbg_reg_we;
   logic        busy;

   logic        load_regs;
   logic [15:0] regs [16];
   logic [5:0]  t2_idx [4];

   int checks_total  = 0;
   int checks_passed = 0;

   reg_debug_sequencer #(
      .NUM_REGS    (16),
      .HALT_TIMEOUT(8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .state          (state),
      .halt_req       (halt_req),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_regnum     (req_regnum),
      .req_count      (req_count),
      .wdata_valid    (wdata_valid),
      .wdata_ready    (wdata_ready),
      .wdata          (wdata),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_data       (rsp_data),
      .rsp_last       (rsp_last),
      .rsp_err        (rsp_err),
      .dbg_reg_rregnum(dbg_reg_rregnum),
      .dbg_reg_rdata  (dbg_reg_rdata),
      .dbg_reg_wregnum(dbg_reg_wregnum),
      .dbg_reg_wdata  (dbg_reg_wdata),
      .dbg_reg_we     (dbg_reg_we),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // Register file: combinational read, write on posedge.
   // Initial contents: regs[i] = C000 + i*0101, except r3 = BEEF, r5 = 1234.
   assign dbg_reg_rdata = regs[dbg_reg_rregnum[3:0]];

   always @(posedge clk) begin
      if (load_regs) begin
         for (int i = 0; i < 16; i++) regs[i] <= 16'hC000 + 16'(i) * 16'h0101;
         regs[3] <= 16'hBEEF;
         regs[5] <= 16'h1234;
      end else if (dbg_reg_we) begin
         regs[dbg_reg_wregnum[3:0]] <= dbg_reg_wdata;
      end
   end

   task automatic check(input string tag, input logic ok,
                        input logic [15:0] obs, input logic [15:0] exp);
      checks_total++;
      if (ok === 1'b1) checks_passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic wr, input logic [5:0] rn, input logic [3:0] cnt);
      req_valid  = 1'b1;
      req_write  = wr;
      req_regnum = rn;
      req_count  = cnt;
      #1;
      cyc();
      req_valid = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      t2_idx      = '{6'd14, 6'd15, 6'd0, 6'd1};
      rst         = 1'b1;
      load_regs   = 1'b1;
      state       = RUNNING;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_regnum  = '0;
      req_count   = '0;
      wdata_valid = 1'b0;
      wdata       = '0;
      rsp_ready   = 1'b0;

      // ---------------- reset ----------------
      cyc();
      cyc();
      check("rst_req_ready_low", req_ready === 1'b0, req_ready, 1'b0);
      rst       = 1'b0;
      load_regs = 1'b0;
      #1;
      check("rst_req_ready", req_ready === 1'b1, req_ready, 1'b1);
      check("rst_busy", busy === 1'b0, busy, 1'b0);
      check("rst_halt_req", halt_req === 1'b0, halt_req, 1'b0);
      check("rst_rsp_valid", rsp_valid === 1'b0, rsp_valid, 1'b0);
      check("rst_we", dbg_reg_we === 1'b0, dbg_reg_we, 1'b0);
      check("rst_wdata_ready", wdata_ready === 1'b0, wdata_ready, 1'b0);
      check("rst_rsp_data", rsp_data === 16'h0000, rsp_data, 16'h0000);
      check("rst_rregnum", dbg_reg_rregnum === 6'd0, dbg_reg_rregnum, 6'd0);

      // ---------------- single read, core already halted ----------------
      state = STATE_HALTED;
      send_req(1'b0, 6'd3, 4'd0);              // now HALT_WAIT
      check("t1_hw_halt_req", halt_req === 1'b1, halt_req, 1'b1);
      check("t1_hw_busy", busy === 1'b1, busy, 1'b1);
      check("t1_hw_req_ready", req_ready === 1'b0, req_ready, 1'b0);
      cyc();                                   // RD_ACCESS
      check("t1_rd_idx", dbg_reg_rregnum === 6'd3, dbg_reg_rregnum, 6'd3);
      check("t1_rd_no_rsp", rsp_valid === 1'b0, rsp_valid, 1'b0);
      cyc();                                   // RD_RESP
      check("t1_rsp_valid", rsp_valid === 1'b1, rsp_valid, 1'b1);
      check("t1_rsp_data", rsp_data === 16'hBEEF, rsp_data, 16'hBEEF);
      check("t1_rsp_last", rsp_last === 1'b1, rsp_last, 1'b1);
      check("t1_rsp_err", rsp_err === 1'b0, rsp_err, 1'b0);
      check("t1_rsp_halt_req", halt_req === 1'b1, halt_req, 1'b1);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      check("t1_idle_busy", busy === 1'b0, busy, 1'b0);
      check("t1_idle_halt_req", halt_req === 1'b0, halt_req, 1'b0);

      // ---------------- write burst 14..1 with wrap ----------------
      state = RUNNING;
      send_req(1'b1, 6'd14, 4'd3);
      check("t2_hw_halt_req", halt_req === 1'b1, halt_req, 1'b1);
      repeat (5) cyc();
      check("t2_wait_busy", busy === 1'b1, busy, 1'b1);
      check("t2_wait_wdata_ready", wdata_ready === 1'b0, wdata_ready, 1'b0);
      state       = STATE_HALTED;
      wdata_valid = 1'b1;
      wdata       = 16'd1;
      #1;
      cyc();                                   // WR_ACCESS
      for (int i = 0; i < 4; i++) begin
         wdata = 16'(i + 1);
         #1;
         check("t2_wdata_ready", wdata_ready === 1'b1, wdata_ready, 1'b1);
         check("t2_we", dbg_reg_we === 1'b1, dbg_reg_we, 1'b1);
         check("t2_widx", dbg_reg_wregnum === t2_idx[i], dbg_reg_wregnum, t2_idx[i]);
         cyc();
      end
      wdata_valid = 1'b0;
      #1;
      check("t2_rsp_valid", rsp_valid === 1'b1, rsp_valid, 1'b1);
      check("t2_rsp_last", rsp_last === 1'b1, rsp_last, 1'b1);
      check("t2_rsp_err", rsp_err === 1'b0, rsp_err, 1'b0);
      check("t2_rsp_data", rsp_data === 16'h0000, rsp_data, 16'h0000);
      check("t2_rsp_no_we", dbg_reg_we === 1'b0, dbg_reg_we, 1'b0);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      check("t2_idle_busy", busy === 1'b0, busy, 1'b0);
      check("t2_r14", regs[14] === 16'd1, regs[14], 16'd1);
      check("t2_r15", regs[15] === 16'd2, regs[15], 16'd2);
      check("t2_r0", regs[0] === 16'd3, regs[0], 16'd3);
      check("t2_r1", regs[1] === 16'd4, regs[1], 16'd4);
      check("t2_r2_untouched", regs[2] === 16'hC202, regs[2], 16'hC202);

      // ---------------- bad regnum ----------------
      send_req(1'b0, 6'd20, 4'd0);             // ERR_RESP directly
      check("t3_rsp_valid", rsp_valid === 1'b1, rsp_valid, 1'b1);
      check("t3_rsp_err", rsp_err === 1'b1, rsp_err, 1'b1);
      check("t3_rsp_last", rsp_last === 1'b1, rsp_last, 1'b1);
      check("t3_rsp_data", rsp_data === 16'h0000, rsp_data, 16'h0000);
      check("t3_halt_req", halt_req === 1'b0, halt_req, 1'b0);
      check("t3_we", dbg_reg_we === 1'b0, dbg_reg_we, 1'b0);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      check("t3_idle_busy", busy === 1'b0, busy, 1'b0);

      // ---------------- halt timeout (HALT_TIMEOUT = 8) ----------------
      state = RUNNING;
      send_req(1'b0, 6'd2, 4'd0);              // HALT_WAIT cycle 0
      for (int i = 0; i < 9; i++) begin
         check("t4_wait_no_rsp", rsp_valid === 1'b0, rsp_valid, 1'b0);
         cyc();
      end                                      // 9 cycles after entry
      check("t4_err_valid", rsp_valid === 1'b1, rsp_valid, 1'b1);
      check("t4_err_err", rsp_err === 1'b1, rsp_err, 1'b1);
      check("t4_err_last", rsp_last === 1'b1, rsp_last, 1'b1);
      check("t4_err_halt_req", halt_req === 1'b1, halt_req, 1'b1);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      check("t4_idle_halt_req", halt_req === 1'b0, halt_req, 1'b0);

      // ---------------- halt arriving on the expiry cycle ----------------
      send_req(1'b0, 6'd5, 4'd0);              // HALT_WAIT cycle 0
      repeat (8) cyc();                        // cycle 8: expiry
      state = STATE_HALTED;
      #1;
      check("t4b_still_waiting", rsp_valid === 1'b0, rsp_valid, 1'b0);
      cyc();                                   // RD_ACCESS, not ERR_RESP
      check("t4b_no_err", rsp_err === 1'b0, rsp_err, 1'b0);
      check("t4b_rd_idx", dbg_reg_rregnum === 6'd5, dbg_reg_rregnum, 6'd5);
      cyc();
      check("t4b_rsp_data", rsp_data === 16'h1234, rsp_data, 16'h1234);
      check("t4b_rsp_err", rsp_err === 1'b0, rsp_err, 1'b0);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;

      // ---------------- halt lost mid read burst ----------------
      send_req(1'b0, 6'd4, 4'd2);              // HALT_WAIT
      cyc();                                   // RD_ACCESS r4
      cyc();                                   // RD_RESP r4
      check("t5a_rsp_data", rsp_data === 16'hC404, rsp_data, 16'hC404);
      check("t5a_rsp_last", rsp_last === 1'b0, rsp_last, 1'b0);
      rsp_ready = 1'b1;
      cyc();                                   // RD_ACCESS r5
      rsp_ready = 1'b0;
      state     = RUNNING;
      #1;
      check("t5a_rd_idx", dbg_reg_rregnum === 6'd5, dbg_reg_rregnum, 6'd5);
      cyc();                                   // ERR_RESP
      check("t5a_err_valid", rsp_valid === 1'b1, rsp_valid, 1'b1);
      check("t5a_err_err", rsp_err === 1'b1, rsp_err, 1'b1);
      check("t5a_err_last", rsp_last === 1'b1, rsp_last, 1'b1);
      check("t5a_err_data", rsp_data === 16'h0000, rsp_data, 16'h0000);
      check("t5a_err_halt_req", halt_req === 1'b1, halt_req, 1'b1);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      check("t5a_idle_busy", busy === 1'b0, busy, 1'b0);

      // ---------------- reset mid write burst ----------------
      state       = STATE_HALTED;
      send_req(1'b1, 6'd8, 4'd3);              // HALT_WAIT
      wdata_valid = 1'b1;
      wdata       = 16'h0101;
      #1;
      cyc();                                   // WR_ACCESS r8
      check("t5b_we_first", dbg_reg_we === 1'b1, dbg_reg_we, 1'b1);
      check("t5b_widx_first", dbg_reg_wregnum === 6'd8, dbg_reg_wregnum, 6'd8);
      cyc();                                   // WR_ACCESS r9
      wdata = 16'h0202;
      rst   = 1'b1;
      #1;
      check("t5b_we_in_rst", dbg_reg_we === 1'b0, dbg_reg_we, 1'b0);
      check("t5b_req_ready_in_rst", req_ready === 1'b0, req_ready, 1'b0);
      cyc();
      rst = 1'b0;
      #1;
      check("t5b_busy", busy === 1'b0, busy, 1'b0);
      check("t5b_halt_req", halt_req === 1'b0, halt_req, 1'b0);
      check("t5b_rsp_valid", rsp_valid === 1'b0, rsp_valid, 1'b0);
      check("t5b_req_ready", req_ready === 1'b1, req_ready, 1'b1);
      cyc();
      check("t5b_no_we", dbg_reg_we === 1'b0, dbg_reg_we, 1'b0);
      check("t5b_no_rsp", rsp_valid === 1'b0, rsp_valid, 1'b0);
      wdata_valid = 1'b0;
      check("t5b_r8", regs[8] === 16'h0101, regs[8], 16'h0101);
      check("t5b_r9", regs[9] === 16'hC909, regs[9], 16'hC909);

      // ---------------- read burst with back-pressure ----------------
      send_req(1'b0, 6'd10, 4'd2);             // HALT_WAIT
      cyc();                                   // RD_ACCESS r10
      cyc();                                   // RD_RESP r10
      check("t6_r0_data", rsp_data === 16'hCA0A, rsp_data, 16'hCA0A);
      check("t6_r0_last", rsp_last === 1'b0, rsp_last, 1'b0);
      cyc();                                   // stalled
      check("t6_r0_hold_valid", rsp_valid === 1'b1, rsp_valid, 1'b1);
      check("t6_r0_hold_data", rsp_data === 16'hCA0A, rsp_data, 16'hCA0A);
      check("t6_r0_hold_last", rsp_last === 1'b0, rsp_last, 1'b0);
      rsp_ready = 1'b1;
      cyc();                                   // RD_ACCESS r11
      rsp_ready = 1'b0;
      #1;
      check("t6_gap_valid", rsp_valid === 1'b0, rsp_valid, 1'b0);
      check("t6_r1_idx", dbg_reg_rregnum === 6'd11, dbg_reg_rregnum, 6'd11);
      cyc();                                   // RD_RESP r11
      check("t6_r1_data", rsp_data === 16'hCB0B, rsp_data, 16'hCB0B);
      cyc();                                   // stalled
      check("t6_r1_hold_data", rsp_data === 16'hCB0B, rsp_data, 16'hCB0B);
      check("t6_r1_hold_last", rsp_last === 1'b0, rsp_last, 1'b0);
      rsp_ready = 1'b1;
      cyc();                                   // RD_ACCESS r12
      rsp_ready = 1'b0;
      #1;
      cyc();                                   // RD_RESP r12
      check("t6_r2_data", rsp_data === 16'hCC0C, rsp_data, 16'hCC0C);
      check("t6_r2_last", rsp_last === 1'b1, rsp_last, 1'b1);
      cyc();                                   // stalled
      check("t6_r2_hold_data", rsp_data === 16'hCC0C, rsp_data, 16'hCC0C);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      check("t6_idle_busy", busy === 1'b0, busy, 1'b0);
      check("t6_idle_halt_req", halt_req === 1'b0, halt_req, 1'b0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
